// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50%-duty
// clock, a rising-edge tick strobe, and accepts glitch-free half-period updates.
module clk_div_multi #(
    parameter int NCH             = 2,
    parameter int NBITS           = 32,
    parameter int REFERENCE_CLOCK = 16_000_000,
    parameter int FREQUENCY       = 153_846
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         en,
    input  logic                   sync,
    input  logic [NCH-1:0]         load,
    input  logic [NCH*NBITS-1:0]   div_in,
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         pend
);

    localparam int                DIV_RAW      = REFERENCE_CLOCK / (2 * FREQUENCY);
    localparam logic [NBITS-1:0]  DEFAULT_HALF = NBITS'((DIV_RAW < 1) ? 1 : DIV_RAW);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [NBITS-1:0] cnt;
        logic [NBITS-1:0] half;
        logic [NBITS-1:0] pending;
        logic [NBITS-1:0] div_slice;
        logic [NBITS-1:0] div_sat;
        logic             out_q;
        logic             tick_q;
        logic             pend_q;
        logic             wrap;

        assign div_slice = div_in[i*NBITS +: NBITS];
        assign div_sat   = (div_slice == '0) ? NBITS'(1) : div_slice;
        assign wrap      = (cnt == half - NBITS'(1));

        // pending always mirrors half while pend_q is low, so applying it
        // unconditionally on disable/sync is the same as applying only when pending.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt     <= '0;
                half    <= DEFAULT_HALF;
                pending <= DEFAULT_HALF;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else if (!en[i] || sync) begin
                cnt     <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
                half    <= load[i] ? div_sat : pending;
                pending <= load[i] ? div_sat : pending;
            end else if (wrap) begin
                cnt    <= '0;
                out_q  <= ~out_q;
                tick_q <= ~out_q;
                pend_q <= 1'b0;
                if (load[i]) begin
                    half    <= div_sat;
                    pending <= div_sat;
                end else if (pend_q) begin
                    half <= pending;
                end
            end else begin
                cnt    <= cnt + NBITS'(1);
                tick_q <= 1'b0;
                if (load[i]) begin
                    pending <= div_sat;
                    pend_q  <= 1'b1;
                end
            end
        end

        assign clk_out[i] = out_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed table-driven bench for clk_div_multi (2 channels, default half-period 52),
// with hand-written sequences for reset defaults and asynchronous mid-count reset.
module tb_clk_div_multi;

    localparam int NCH   = 2;
    localparam int NBITS = 32;

    logic                 clk;
    logic                 reset;
    logic [NCH-1:0]       en;
    logic                 sync;
    logic [NCH-1:0]       load;
    logic [NCH*NBITS-1:0] div_in;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       pend;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] en;
        logic       sync;
        logic [1:0] load;
        logic [31:0] div0;
        logic [31:0] div1;
        int         cycles;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
        logic [1:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    clk_div_multi #(.NCH(NCH), .NBITS(NBITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sync    (sync),
        .load    (load),
        .div_in  (div_in),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input string name, input logic [1:0] e, input logic s,
                       input logic [1:0] l, input logic [31:0] d0, input logic [31:0] d1,
                       input int n, input logic [1:0] ec, input logic [1:0] et,
                       input logic [1:0] ep);
        vec_t v;
        v.name = name; v.en = e; v.sync = s; v.load = l; v.div0 = d0; v.div1 = d1;
        v.cycles = n; v.exp_clk = ec; v.exp_tick = et; v.exp_pend = ep;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [1:0] ec,
                                input logic [1:0] et, input logic [1:0] ep);
        checks++;
        if (clk_out !== ec) begin
            errors++;
            $display("[TB] FAIL %s clk_out: got %b expected %b", name, clk_out, ec);
        end
        checks++;
        if (tick !== et) begin
            errors++;
            $display("[TB] FAIL %s tick: got %b expected %b", name, tick, et);
        end
        checks++;
        if (pend !== ep) begin
            errors++;
            $display("[TB] FAIL %s pend: got %b expected %b", name, pend, ep);
        end
    endtask

    // Inputs change at the falling edge; strobes last exactly one rising edge.
    task automatic apply_stimulus(input vec_t v);
        en     = v.en;
        sync   = v.sync;
        load   = v.load;
        div_in = {v.div1, v.div0};
        @(negedge clk);
        sync = 1'b0;
        load = '0;
        for (int k = 1; k < v.cycles; k++) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        en     = '0;
        sync   = 1'b0;
        load   = '0;
        div_in = '0;

        //            name           en    sy  load   d0  d1  n   clk    tick   pend
        add("en_first",     2'b11, 0, 2'b00, 0, 0, 1,  2'b00, 2'b00, 2'b00);
        add("pre_rise",     2'b11, 0, 2'b00, 0, 0, 50, 2'b00, 2'b00, 2'b00);
        add("first_rise",   2'b11, 0, 2'b00, 0, 0, 1,  2'b11, 2'b11, 2'b00);
        add("tick_drop",    2'b11, 0, 2'b00, 0, 0, 1,  2'b11, 2'b00, 2'b00);
        add("pre_fall",     2'b11, 0, 2'b00, 0, 0, 50, 2'b11, 2'b00, 2'b00);
        add("first_fall",   2'b11, 0, 2'b00, 0, 0, 1,  2'b00, 2'b00, 2'b00);
        add("to_cnt10",     2'b11, 0, 2'b00, 0, 0, 10, 2'b00, 2'b00, 2'b00);
        add("load3",        2'b11, 0, 2'b01, 3, 0, 1,  2'b00, 2'b00, 2'b01);
        add("pend_hold",    2'b11, 0, 2'b00, 0, 0, 39, 2'b00, 2'b00, 2'b01);
        add("pend_cnt51",   2'b11, 0, 2'b00, 0, 0, 1,  2'b00, 2'b00, 2'b01);
        add("load3_apply",  2'b11, 0, 2'b00, 0, 0, 1,  2'b11, 2'b11, 2'b00);
        add("half3_fall",   2'b11, 0, 2'b00, 0, 0, 3,  2'b10, 2'b00, 2'b00);
        add("half3_rise",   2'b11, 0, 2'b00, 0, 0, 3,  2'b11, 2'b01, 2'b00);
        add("load0_ch1",    2'b11, 0, 2'b10, 0, 0, 1,  2'b11, 2'b00, 2'b10);
        add("ch1_disable",  2'b01, 0, 2'b00, 0, 0, 1,  2'b01, 2'b00, 2'b00);
        add("div1_rise_a",  2'b11, 0, 2'b00, 0, 0, 1,  2'b10, 2'b10, 2'b00);
        add("div1_fall_a",  2'b11, 0, 2'b00, 0, 0, 1,  2'b00, 2'b00, 2'b00);
        add("div1_rise_b",  2'b11, 0, 2'b00, 0, 0, 1,  2'b10, 2'b10, 2'b00);
        add("div1_fall_b",  2'b11, 0, 2'b00, 0, 0, 1,  2'b01, 2'b01, 2'b00);
        add("sync_load",    2'b11, 1, 2'b11, 2, 3, 1,  2'b00, 2'b00, 2'b00);
        add("sync_plus1",   2'b11, 0, 2'b00, 0, 0, 1,  2'b00, 2'b00, 2'b00);
        add("sync_ch0_up",  2'b11, 0, 2'b00, 0, 0, 1,  2'b01, 2'b01, 2'b00);
        add("sync_ch1_up",  2'b11, 0, 2'b00, 0, 0, 1,  2'b11, 2'b10, 2'b00);
        add("load_at_wrap", 2'b11, 0, 2'b01, 5, 0, 1,  2'b10, 2'b00, 2'b00);
        add("half5_low",    2'b11, 0, 2'b00, 0, 0, 4,  2'b00, 2'b00, 2'b00);
        add("half5_rise",   2'b11, 0, 2'b00, 0, 0, 1,  2'b11, 2'b11, 2'b00);
        add("reload_a",     2'b11, 0, 2'b10, 0, 7, 1,  2'b11, 2'b00, 2'b10);
        add("reload_b",     2'b11, 0, 2'b10, 0, 4, 1,  2'b11, 2'b00, 2'b10);
        add("reload_wrap",  2'b11, 0, 2'b00, 0, 0, 1,  2'b01, 2'b00, 2'b00);
        add("half4_low",    2'b11, 0, 2'b00, 0, 0, 3,  2'b00, 2'b00, 2'b00);
        add("half4_rise",   2'b11, 0, 2'b00, 0, 0, 1,  2'b10, 2'b10, 2'b00);

        @(negedge clk);
        check_output("reset_state", 2'b00, 2'b00, 2'b00);
        reset = 1'b1;

        foreach (vecs[n]) begin
            apply_stimulus(vecs[n]);
            check_output(vecs[n].name, vecs[n].exp_clk, vecs[n].exp_tick, vecs[n].exp_pend);
        end

        // Asynchronous reset between clock edges, with ch1 output high beforehand.
        #2 reset = 1'b0;
        #1 check_output("async_reset", 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        en    = 2'b11;
        for (int k = 0; k < 51; k++) @(negedge clk);
        check_output("post_reset_51", 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check_output("post_reset_52", 2'b11, 2'b11, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
